// File: rtl/flash_prom_zet_prog_if.sv
// Host-side command/status bundle for the NOR flash program/erase block.
interface flash_prom_zet_prog_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_erase;
  logic [20:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        timeout;
  logic [7:0]  status;

  modport master (
    output cmd_valid, cmd_erase, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, err, timeout, status
  );

  modport slave (
    input  cmd_valid, cmd_erase, cmd_addr, cmd_data,
    output cmd_ready, busy, done, err, timeout, status
  );
endinterface

// File: rtl/flash_prom_zet_prog.sv
// Intel-command-set NOR flash word program / block erase sequencer with status polling.
// Optional `define FLASH_PROG_VERIFY_EN adds a read-back verify of programmed words.
module flash_prom_zet_prog #(
  parameter int unsigned T_SU      = 2,
  parameter int unsigned T_WP      = 4,
  parameter int unsigned T_WH      = 2,
  parameter int unsigned T_ACC     = 6,
  parameter int unsigned TO_CYCLES = 100000000
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  flash_prom_zet_prog_if.slave host,
  output logic                 NF_WE,
  output logic                 NF_CE,
  output logic                 NF_OE,
  output logic                 NF_BYTE,
  output logic [20:0]          NF_A,
  input  logic [15:0]          NF_D_in,
  output logic [15:0]          NF_D_out,
  output logic                 NF_D_oe
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_POLL   = 3'd4;
  localparam logic [2:0] S_ARRAY  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
`ifdef FLASH_PROG_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd7;
`endif

  localparam logic [2:0] B_IDLE = 3'd0;
  localparam logic [2:0] B_SU   = 3'd1;
  localparam logic [2:0] B_WP   = 3'd2;
  localparam logic [2:0] B_WH   = 3'd3;
  localparam logic [2:0] B_WREC = 3'd4;
  localparam logic [2:0] B_RACC = 3'd5;
  localparam logic [2:0] B_RREC = 3'd6;

  logic [2:0]  state;
  logic [2:0]  phase;
  logic [7:0]  cnt;
  logic        erase_q;
  logic [15:0] data_q;
  logic [15:0] rd_data;
  logic [31:0] to_cnt;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        timeout_q;
  logic [7:0]  status_q;

  logic        bus_last;
  logic        launch_wr;
  logic        launch_rd;
  logic [15:0] wr_val;
  logic        sr_ready;
  logic        timed_out;

  assign bus_last  = (phase == B_WREC) || (phase == B_RREC);
  assign sr_ready  = rd_data[7];
  assign timed_out = (to_cnt >= TO_CYCLES);

  assign host.cmd_ready = ready_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.err       = err_q;
  assign host.timeout   = timeout_q;
  assign host.status    = status_q;
  assign NF_BYTE        = 1'b1;

`ifndef FLASH_PROG_VERIFY_EN
  logic unused_hi;
  assign unused_hi = ^rd_data[15:8];
`endif

  // The next bus cycle is launched in the recovery cycle of the previous one, so the
  // command sequence runs back to back with exactly one CE-high cycle between accesses.
  always_comb begin
    launch_wr = 1'b0;
    launch_rd = 1'b0;
    wr_val    = 16'h0000;
    if (state == S_IDLE) begin
      if (host.cmd_valid) begin
        launch_wr = 1'b1;
        wr_val    = 16'h0050;
      end
    end else if (bus_last) begin
      case (state)
        S_CLR: begin
          launch_wr = 1'b1;
          wr_val    = erase_q ? 16'h0020 : 16'h0040;
        end
        S_SETUP: begin
          launch_wr = 1'b1;
          wr_val    = erase_q ? 16'h00D0 : data_q;
        end
        S_DATA: launch_rd = 1'b1;
        S_POLL: begin
          if (!sr_ready && !timed_out) begin
            launch_rd = 1'b1;
          end else begin
            launch_wr = 1'b1;
            wr_val    = 16'h00FF;
          end
        end
`ifdef FLASH_PROG_VERIFY_EN
        S_ARRAY: launch_rd = !erase_q && !err_q;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      erase_q   <= 1'b0;
      data_q    <= 16'h0000;
      to_cnt    <= 32'd0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      status_q  <= 8'h00;
      NF_A      <= 21'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host.cmd_valid) begin
            erase_q   <= host.cmd_erase;
            data_q    <= host.cmd_data;
            NF_A      <= host.cmd_addr;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            state     <= S_CLR;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          if (state == S_POLL && to_cnt != 32'hFFFF_FFFF) to_cnt <= to_cnt + 32'd1;
          if (bus_last) begin
            case (state)
              S_CLR:   state <= S_SETUP;
              S_SETUP: state <= S_DATA;
              S_DATA: begin
                state  <= S_POLL;
                to_cnt <= 32'd0;
              end
              S_POLL: begin
                // A ready status wins over a timeout reached on the same read.
                if (sr_ready) begin
                  status_q <= rd_data[7:0];
                  err_q    <= rd_data[5] | rd_data[4] | rd_data[3] | rd_data[1];
                  state    <= S_ARRAY;
                end else if (timed_out) begin
                  timeout_q <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= S_ARRAY;
                end
              end
              S_ARRAY: begin
`ifdef FLASH_PROG_VERIFY_EN
                if (launch_rd) begin
                  state <= S_VERIFY;
                end else begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                end
`else
                state  <= S_DONE;
                done_q <= 1'b1;
`endif
              end
`ifdef FLASH_PROG_VERIFY_EN
              S_VERIFY: begin
                if (rd_data != data_q) err_q <= 1'b1;
                state  <= S_DONE;
                done_q <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Shared bus-cycle engine; pins are registered so strobes never glitch on phase changes.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= B_IDLE;
      cnt      <= 8'd0;
      NF_WE    <= 1'b1;
      NF_CE    <= 1'b1;
      NF_OE    <= 1'b1;
      NF_D_oe  <= 1'b0;
      NF_D_out <= 16'h0000;
      rd_data  <= 16'h0000;
    end else if (launch_wr) begin
      phase    <= B_SU;
      cnt      <= 8'(T_SU - 1);
      NF_CE    <= 1'b0;
      NF_WE    <= 1'b1;
      NF_OE    <= 1'b1;
      NF_D_oe  <= 1'b1;
      NF_D_out <= wr_val;
    end else if (launch_rd) begin
      phase   <= B_RACC;
      cnt     <= 8'(T_ACC - 1);
      NF_CE   <= 1'b0;
      NF_OE   <= 1'b0;
      NF_WE   <= 1'b1;
      NF_D_oe <= 1'b0;
    end else begin
      if (cnt != 8'd0) cnt <= cnt - 8'd1;
      case (phase)
        B_SU: begin
          if (cnt == 8'd0) begin
            phase <= B_WP;
            cnt   <= 8'(T_WP - 1);
            NF_WE <= 1'b0;
          end
        end
        B_WP: begin
          if (cnt == 8'd0) begin
            phase <= B_WH;
            cnt   <= 8'(T_WH - 1);
            NF_WE <= 1'b1;
          end
        end
        B_WH: begin
          if (cnt == 8'd0) begin
            phase   <= B_WREC;
            NF_CE   <= 1'b1;
            NF_D_oe <= 1'b0;
          end
        end
        B_RACC: begin
          if (cnt == 8'd0) begin
            phase   <= B_RREC;
            NF_CE   <= 1'b1;
            NF_OE   <= 1'b1;
            rd_data <= NF_D_in;
          end
        end
        default: phase <= B_IDLE;
      endcase
    end
  end

endmodule
